// File: rtl/expr_eval_pipe.sv
// Single-entry expression evaluator: one-cycle ALU ops, plus a WIDTH-cycle restoring divider
// for DIV/MOD. The result is held in DONE until the consumer takes it.
module expr_eval_pipe #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned OUT_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             dbz
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpMul = 3'd2;
  localparam logic [2:0] OpDiv = 3'd3;
  localparam logic [2:0] OpMod = 3'd4;
  localparam logic [2:0] OpShl = 3'd5;
  localparam logic [2:0] OpShr = 3'd6;
  localparam logic [2:0] OpLt  = 3'd7;

  localparam int unsigned   CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH:0]  OutWB   = (WIDTH + 1)'(OUT_W);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             r_state, w_state_nxt;
  logic [OUT_W-1:0]   r_result;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_quo, r_dvs, r_rem;
  logic [CntW-1:0]    r_cnt;
  logic               r_qneg, r_rneg, r_is_mod, r_bz;
  logic [OUT_W-1:0]   r_a_ext;

  logic               w_accept, w_is_div, w_shamt_big;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [OUT_W-1:0]   w_a_ext, w_b_ext, w_fast_res, w_div_res;
  logic [WIDTH:0]     w_shift, w_trial;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt;
  logic [OUT_W-1:0]   w_q_ext, w_r_ext;

  assign in_ready  = (r_state == StIdle) || ((r_state == StDone) && out_ready);
  assign out_valid = (r_state == StDone);
  assign result    = r_result;
  assign dbz       = r_dbz;

  assign w_accept    = in_valid && in_ready;
  assign w_is_div    = (op == OpDiv) || (op == OpMod);
  assign w_a_neg     = sgn & a[WIDTH-1];
  assign w_b_neg     = sgn & b[WIDTH-1];
  assign w_a_ext     = {{(OUT_W - WIDTH){w_a_neg}}, a};
  assign w_b_ext     = {{(OUT_W - WIDTH){w_b_neg}}, b};
  assign w_a_mag     = w_a_neg ? -a : a;
  assign w_b_mag     = w_b_neg ? -b : b;
  assign w_shamt_big = ({1'b0, b} >= OutWB);

  always_comb begin
    w_fast_res = '0;
    case (op)
      OpAdd: w_fast_res = w_a_ext + w_b_ext;
      OpSub: w_fast_res = w_a_ext - w_b_ext;
      OpMul: w_fast_res = w_a_ext * w_b_ext;
      OpShl: w_fast_res = w_shamt_big ? '0 : (w_a_ext << b);
      OpShr: begin
        // Kept as separate branches so >>> is not forced into unsigned context.
        if (w_shamt_big)  w_fast_res = {OUT_W{w_a_neg}};
        else if (sgn)     w_fast_res = $signed(w_a_ext) >>> b;
        else              w_fast_res = w_a_ext >> b;
      end
      OpLt:  w_fast_res = {{(OUT_W - 1){1'b0}}, ($signed(w_a_ext) < $signed(w_b_ext))};
      default: w_fast_res = '0;
    endcase
  end

  // One restoring step: shift in the next dividend bit, keep the trial if it stays non-negative.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_qbit    = ~w_trial[WIDTH];
  assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};
  assign w_q_ext   = {{(OUT_W - WIDTH){1'b0}}, w_quo_nxt};
  assign w_r_ext   = {{(OUT_W - WIDTH){1'b0}}, w_rem_nxt};

  always_comb begin
    w_div_res = '0;
    if (r_bz)          w_div_res = r_is_mod ? r_a_ext : '1;
    else if (r_is_mod) w_div_res = r_rneg ? -w_r_ext : w_r_ext;
    else               w_div_res = r_qneg ? -w_q_ext : w_q_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle, StDone: begin
        if (w_accept)                            w_state_nxt = w_is_div ? StCalc : StDone;
        else if ((r_state == StDone) && out_ready) w_state_nxt = StIdle;
      end
      StCalc: if (r_cnt == LastCnt) w_state_nxt = StDone;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_dbz    <= 1'b0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_is_mod <= 1'b0;
      r_bz     <= 1'b0;
      r_a_ext  <= '0;
    end else if (w_accept) begin
      r_quo    <= w_a_mag;
      r_dvs    <= w_b_mag;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_qneg   <= w_a_neg ^ w_b_neg;
      r_rneg   <= w_a_neg;
      r_is_mod <= (op == OpMod);
      r_bz     <= (b == '0);
      r_a_ext  <= w_a_ext;
      if (!w_is_div) begin
        r_result <= w_fast_res;
        r_dbz    <= 1'b0;
      end
    end else if (r_state == StCalc) begin
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LastCnt) begin
        r_result <= w_div_res;
        r_dbz    <= r_bz;
      end
    end
  end

endmodule

// File: doc/expr_eval_pipe.md
EXPR_EVAL_PIPE -- requirements
Module: expr_eval_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter OUT_W, fixed at 2*WIDTH, giving the result width.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port in_valid, input, 1, high when a command is presented.
REQ-006 Port in_ready, output, 1, high when the block can accept a command.
REQ-007 Port op, input, 3, operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 SHL, 6 SHR, 7 LT.
REQ-008 Port sgn, input, 1, 1 = operands are two's-complement signed, 0 = unsigned.
REQ-009 Port a, input, WIDTH, first operand.
REQ-010 Port b, input, WIDTH, second operand.
REQ-011 Port out_valid, output, 1, high while a result is held.
REQ-012 Port out_ready, input, 1, high when the consumer takes the result.
REQ-013 Port result, output, OUT_W, the operation result.
REQ-014 Port dbz, output, 1, divide-by-zero flag qualified by out_valid.

Function
REQ-015 A command SHALL be accepted on a rising edge where in_valid and in_ready are both high; a, b, op and sgn are captured on that edge.
REQ-016 The block SHALL be single-entry, with states IDLE, CALC and DONE.
REQ-017 in_ready SHALL be high in IDLE, and high in DONE when out_ready is high (back-to-back acceptance); it SHALL be low in CALC.
REQ-018 Before the operation, both operands SHALL be extended to OUT_W: sign-extended if sgn=1, zero-extended otherwise.
REQ-019 ADD, SUB, MUL, SHL, SHR and LT SHALL go from IDLE/DONE to DONE, with out_valid high on the cycle after acceptance (latency 1).
REQ-020 DIV and MOD SHALL enter CALC and run a restoring divider on magnitudes for exactly WIDTH cycles, then enter DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-021 ADD, SUB and MUL SHALL return the extended-operand result modulo 2^OUT_W; no overflow is possible for MUL.
REQ-022 Signed DIV SHALL truncate toward zero; signed MOD SHALL take the sign of the dividend.
REQ-023 Signed DIV of the most negative value by -1 SHALL return +2^(WIDTH-1), which is representable in OUT_W bits.
REQ-024 When b == 0 for DIV or MOD: result SHALL be all ones for DIV and the extended a for MOD, dbz SHALL be 1, and the latency SHALL still be WIDTH+1.
REQ-025 dbz SHALL be 0 for every other result.
REQ-026 Shift amount SHALL be b taken as unsigned.
REQ-027 SHL SHALL shift extended a left; SHR SHALL shift arithmetically when sgn=1 and logically when sgn=0.
REQ-028 For amounts >= OUT_W: SHL SHALL give 0; SHR SHALL give all copies of the sign bit (sgn=1) or 0 (sgn=0).
REQ-029 LT SHALL return 1 in bit 0 and zeros elsewhere if a < b under the sgn interpretation, else 0.
REQ-030 In DONE, result and dbz SHALL stay stable until out_ready is high.
REQ-031 Handshake in DONE: out_ready high with no new command returns to IDLE; out_ready high with a new command loads it in the same edge; out_ready low holds.
REQ-032 in_valid while in_ready is low SHALL be ignored, and the inputs need not be held stable.

Reset
REQ-033 While reset is high: state = IDLE, out_valid = 0, result = 0, dbz = 0, divider registers = 0, and in_ready = 1 once reset is released.
REQ-034 Reset asserted mid-CALC or in DONE SHALL abort the operation with no result emitted.

Verification
REQ-035 WIDTH=6: ADD with sgn=1, a=6'b111111, b=6'b000001 -> result 12'h000 one cycle later.
REQ-036 WIDTH=6: DIV with sgn=1, a=-32, b=-1 -> result 12'd32 (not 12'hFE0), dbz=0, out_valid at cycle 7.
REQ-037 WIDTH=6: MOD with sgn=0, a=13, b=0 -> result 12'd13, dbz=1; then DIV with sgn=1, a=-7, b=2 -> quotient 12'hFFD.
REQ-038 WIDTH=6: SHR with sgn=1, a=-4, b=40 -> 12'hFFF; SHL with a=1, b=11 -> 12'h800; SHL with b=12 -> 0.
REQ-039 Hold out_ready low for 5 cycles after a MUL -> result stable and in_ready low; then out_ready high together with in_valid -> the next command is accepted on the same edge.
REQ-040 Assert reset at cycle 3 of a DIV -> out_valid never rises for it; after release, LT with sgn=0, a=2, b=63 -> result 1.
